// File: rtl/ifft32_sdf_ctrl_if.sv
// Control bundle between the SDF IFFT sequencer (master) and the
// sample source / butterfly datapath (slave).
interface ifft32_sdf_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_take;
    logic       pipe_en;
    logic [4:0] bf_sel;
    logic [3:0] tw_mul;
    logic [3:0] tw_addr32;
    logic [2:0] tw_addr16;
    logic [1:0] tw_addr8;
    logic       tw_addr4;
    logic       out_valid;
    logic [4:0] out_idx;
    logic       busy;

    modport master (
        input  in_valid,
        output in_ready, in_take, pipe_en, bf_sel, tw_mul,
        output tw_addr32, tw_addr16, tw_addr8, tw_addr4,
        output out_valid, out_idx, busy
    );

    modport slave (
        output in_valid,
        input  in_ready, in_take, pipe_en, bf_sel, tw_mul,
        input  tw_addr32, tw_addr16, tw_addr8, tw_addr4,
        input  out_valid, out_idx, busy
    );
endinterface

// File: rtl/ifft32_sdf_ctrl.sv
// Sequencer for the 32-point radix-2 SDF IFFT: master sample counter, stage
// select / twiddle decode and flagging of bit-reversed output samples.
module ifft32_sdf_ctrl (
    input  logic              clk,
    input  logic              rst,
    ifft32_sdf_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t     r_state;
    logic [4:0] r_cnt;
    // r_live[0]: a frame was taken in the previous lap; r_live[1]: the lap before
    logic [1:0] r_live;

    logic       w_ready;
    logic       w_take;
    logic       w_pipe_en;
    logic       w_wrap;
    logic       w_last_out;
    logic [4:0] w_cout;
    logic [3:0] w_c2_lo;
    logic [2:0] w_c3_lo;
    logic [1:0] w_c4_lo;
    logic [4:0] w_bf;
    logic [3:0] w_mul;

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

    // Handshake and clock-enable; reset holds the enable low
    always_comb begin
        w_ready = 1'b1;
        case (r_state)
            ST_IDLE:  w_ready = 1'b1;
            ST_RUN:   w_ready = 1'b1;
            ST_FLUSH: w_ready = (r_cnt == 5'd0);
            default:  w_ready = 1'b1;
        endcase
        w_take = bus.in_valid & w_ready & ~rst;
        if (r_state == ST_FLUSH) begin
            w_pipe_en = ~rst;
        end else begin
            w_pipe_en = w_take;
        end
        w_wrap     = w_pipe_en & (r_cnt == 5'd31);
        w_last_out = w_pipe_en & (r_cnt == 5'd3);
    end

    // Stage local counts, computed only as wide as the bits each stage uses
    always_comb begin
        w_c2_lo = r_cnt[3:0] - 4'd1;
        w_c3_lo = r_cnt[2:0] - 3'd2;
        w_c4_lo = r_cnt[1:0] - 2'd3;
        w_cout  = r_cnt - 5'd4;
        w_bf    = 5'd0;
        if (r_state == ST_IDLE) begin
            w_bf = 5'd0;
        end else begin
            // offset 34 is even, so stage 5 sees the raw count LSB
            w_bf = {r_cnt[0], w_c4_lo[1], w_c3_lo[2], w_c2_lo[3], r_cnt[4]};
        end
        w_mul = ~w_bf[3:0];
    end

    assign bus.in_ready  = w_ready | rst;
    assign bus.in_take   = w_take;
    assign bus.pipe_en   = w_pipe_en;
    assign bus.bf_sel    = w_bf;
    assign bus.tw_mul    = w_mul;
    assign bus.tw_addr32 = w_mul[0] ? r_cnt[3:0] : 4'd0;
    assign bus.tw_addr16 = w_mul[1] ? w_c2_lo[2:0] : 3'd0;
    assign bus.tw_addr8  = w_mul[2] ? w_c3_lo[1:0] : 2'd0;
    assign bus.tw_addr4  = w_mul[3] ? w_c4_lo[0] : 1'b0;
    // Output counts 0..3 of a lap belong to the frame from two laps back
    assign bus.out_valid = w_pipe_en & ((r_cnt < 5'd4) ? r_live[1] : r_live[0]);
    assign bus.out_idx   = bitrev5(w_cout);
    assign bus.busy      = (r_state != ST_IDLE);

    // Sequencer FSM, master counter and live-frame tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_live  <= 2'b00;
        end else if (w_pipe_en) begin
            r_cnt <= r_cnt + 5'd1;
            if (w_wrap) begin
                r_live <= {r_live[0], (r_state == ST_RUN)};
            end else if (w_last_out) begin
                r_live[1] <= 1'b0;
            end else begin
                r_live <= r_live;
            end
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (r_cnt == 5'd31) begin
                        r_state <= ST_FLUSH;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (w_take) begin
                        r_state <= ST_RUN;
                    end else if (w_last_out && !r_live[0]) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 5'd0;
                    end else begin
                        r_state <= ST_FLUSH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 5'd0;
                end
            endcase
        end else begin
            r_state <= r_state;
            r_cnt   <= r_cnt;
            r_live  <= r_live;
        end
    end
endmodule

// File: tb/tb_ifft32_sdf_ctrl.sv
// Directed scoreboard bench for ifft32_sdf_ctrl: expected outputs are queued
// at stimulus time and a negedge monitor pops them as out_valid appears.
module tb_ifft32_sdf_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    typedef struct {
        int         cyc;
        logic [4:0] idx;
    } exp_t;
    exp_t exp_q[$];

    ifft32_sdf_ctrl_if bus ();

    ifft32_sdf_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4:0] bitrev(input int v);
        logic [4:0] r;
        r = 5'd0;
        for (int b = 0; b < 5; b++) r[4-b] = v[b];
        return r;
    endfunction

    // Scoreboard monitor: every out_valid must match the head of the queue
    always @(negedge clk) begin
        exp_t e;
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", cyc, -1);
            end else begin
                e = exp_q.pop_front();
                check("out_cycle", cyc, e.cyc);
                check("out_idx", int'(bus.out_idx), int'(e.idx));
            end
        end
    end

    function automatic logic vin(input int kind, input int rel);
        case (kind)
            1, 5:    return (rel < 32);
            2:       return (rel < 64);
            3:       return (rel < 11) || (rel >= 14 && rel < 35);
            4:       return (rel < 32) || (rel >= 40 && rel < 96);
            default: return 1'b0;
        endcase
    endfunction

    task automatic push_frame(input int first_cyc, input int n);
        for (int c = 0; c < n; c++) exp_q.push_back('{cyc: first_cyc + c, idx: bitrev(c % 32)});
    endtask

    task automatic run_test(input int kind, input int ncyc);
        int t0;
        t0 = 0;
        for (int rel = 0; rel < ncyc; rel++) begin
            @(posedge clk);
            #1;
            if (rel == 0) begin
                t0 = cyc;
                case (kind)
                    1:       push_frame(t0 + 36, 32);
                    2:       push_frame(t0 + 36, 64);
                    3:       push_frame(t0 + 39, 32);
                    4:       begin push_frame(t0 + 36, 32); push_frame(t0 + 100, 32); end
                    5:       push_frame(t0 + 36, 14);
                    default: ;
                endcase
            end
            bus.in_valid = vin(kind, rel);
            rst = (kind == 5 && rel == 50);
            @(negedge clk);
            if (kind == 1 && rel == 20) begin
                check("t20_bf_sel", int'(bus.bf_sel), 1);     // 5'b00001
                check("t20_tw_mul", int'(bus.tw_mul), 14);    // 4'b1110
                check("t20_tw_addr32", int'(bus.tw_addr32), 0);
                check("t20_tw_addr16", int'(bus.tw_addr16), 3);
                check("t20_tw_addr8", int'(bus.tw_addr8), 2);
                check("t20_tw_addr4", int'(bus.tw_addr4), 1);
            end
            if (kind == 1 && rel == 32) begin
                check("flush_pipe_en", int'(bus.pipe_en), 1);
                check("flush_in_take", int'(bus.in_take), 0);
                check("flush_cnt0_ready", int'(bus.in_ready), 1);
            end
            if (kind == 1 && rel == 67) check("single_busy67", int'(bus.busy), 1);
            if (kind == 1 && rel == 68) check("single_busy68", int'(bus.busy), 0);
            if (kind == 2 && rel == 99) check("b2b_busy99", int'(bus.busy), 1);
            if (kind == 2 && rel == 100) check("b2b_busy100", int'(bus.busy), 0);
            if (kind == 3 && rel >= 11 && rel <= 13) begin
                check("gap_pipe_en", int'(bus.pipe_en), 0);
                check("gap_bf_sel", int'(bus.bf_sel), 18);    // 5'b10010 at cnt 11
                check("gap_tw_addr32", int'(bus.tw_addr32), 11);
                check("gap_tw_addr8", int'(bus.tw_addr8), 1);
            end
            if (kind == 3 && rel == 71) check("gap_busy71", int'(bus.busy), 0);
            if (kind == 4 && rel == 45) begin
                check("refuse_in_ready", int'(bus.in_ready), 0);
                check("refuse_in_take", int'(bus.in_take), 0);
                check("refuse_pipe_en", int'(bus.pipe_en), 1);
            end
            if (kind == 4 && rel == 64) begin
                check("accept_in_ready", int'(bus.in_ready), 1);
                check("accept_in_take", int'(bus.in_take), 1);
            end
            if (kind == 4 && rel == 132) check("flushint_busy", int'(bus.busy), 0);
            if (kind == 5 && rel == 51) begin
                check("rstflush_busy", int'(bus.busy), 0);
                check("rstflush_pipe_en", int'(bus.pipe_en), 0);
            end
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_pipe_en", int'(bus.pipe_en), 0);
        check("rst_in_take", int'(bus.in_take), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_bf_sel", int'(bus.bf_sel), 0);
        check("rst_tw_mul", int'(bus.tw_mul), 15);
        check("rst_tw_addr32", int'(bus.tw_addr32), 0);
        check("rst_out_idx", int'(bus.out_idx), 7);       // bitrev(0 - 4 mod 32 = 28)
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;

        run_test(1, 72);
        run_test(2, 104);
        run_test(3, 75);
        run_test(4, 136);
        run_test(5, 120);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ifft32_sdf_ctrl.md
# ifft32_sdf_ctrl

Sequencer for the 32-point radix-2 single-path delay-feedback (SDF) IFFT pipeline. It owns the master sample counter and does four things:
- Gates the pipeline clock-enable.
- Drives the per-stage butterfly selects and multiplier selects.
- Generates the twiddle ROM addresses for the 16-, 8-, 4- and 2-entry twiddle tables.
- Flags valid, bit-reversed-indexed output samples, including flushing the pipeline after the last frame.

It sits between the sample source and the five SDF butterfly stages.

## Interface
No parameters: the block is fixed to N=32.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  source presents a sample this cycle.
- in_ready  out  1  controller can accept a sample this cycle.
- in_take  out  1  in_valid & in_ready. Datapath muxes its input to zero when this is low and pipe_en is high.
- pipe_en  out  1  clock-enable for every datapath register, delay line and output register.
- bf_sel  out  5  bit k-1 = butterfly select of stage k (1 = butterfly/sum-out, 0 = feedback/difference-out).
- tw_mul  out  4  bit k-1 = stage k multiplier select (1 = multiply by ROM word, 0 = bypass).
- tw_addr32  out  4  stage-1 ROM address (W32^n, n=0..15).
- tw_addr16  out  3  stage-2 ROM address (W32^2n).
- tw_addr8  out  2  stage-3 ROM address (W32^4n).
- tw_addr4  out  1  stage-4 ROM address (W32^8n).
- out_valid  out  1  last-stage output holds a real sample this cycle.
- out_idx  out  5  natural frequency index of the current output: bit-reverse of the output local count.
- busy  out  1  state != IDLE.

## Operation
**States and transitions**
- IDLE:
  - cnt = 0 and in_ready = 1.
  - pipe_en = in_take.
  - First in_take moves to RUN.
- RUN:
  - in_ready = 1 and pipe_en = in_take.
  - A mid-frame gap (in_valid low) freezes everything: counter, datapath and all outputs.
  - When sample 31 is taken: if in_valid is high at the next cnt==0 cycle, stay in RUN; otherwise go to FLUSH.
- FLUSH:
  - pipe_en = 1 every cycle; zeros are fed in.
  - in_ready = 1 only when cnt==0, i.e. on a frame boundary. An in_take there returns the block to RUN without a bubble.
  - Returns to IDLE in the cycle after the output sample with local count 31 of the last accepted frame.

**Master counter**
- cnt is 5 bits and advances by 1 on every pipe_en cycle, wrapping 31 to 0.

**Stage local counts**
- Each stage k uses c_k = (cnt − O_k) mod 32.
- Offsets: O_1=0, O_2=17, O_3=26, O_4=31, O_5=34, output O_out=36.
- These offsets come from a delay of 16, 8, 4, 2, 1 per stage plus 1 register per stage.

**Butterfly select**
- bf_sel[k-1] = c_k[5-k].

**Twiddle (stages 1–4)**
- tw_mul[k-1] = ~bf_sel[k-1].
- Address = low (5-k) bits of c_k when tw_mul is 1, otherwise 0 (W^0).
  - tw_addr32 = c_1[3:0]
  - tw_addr16 = c_2[2:0]
  - tw_addr8 = c_3[1:0]
  - tw_addr4 = c_4[0]
- Stage 5 has no multiplier.
- The IFFT conjugation is done in the datapath, not here.

**Output**
- Output local count c_out = cnt − 36 mod 32, which equals cnt − 4.
- out_idx = bitrev5(c_out).
- out_valid = pipe_en AND c_out belongs to an accepted frame.
  - At most two frames are in flight, so two live-frame flags are tracked; each is set when a frame is taken and cleared when that frame's c_out=31 is output.
- Garbage from the start-up or flush phases never raises out_valid.

**Reset values**
- State IDLE and cnt=0.
- in_ready=1, pipe_en=0, in_take=0.
- bf_sel=0, tw_mul=5'b01111 truncated to 4'b1111 when decoded from cnt=0 (i.e. tw_mul=4'b1111), all tw_addr as decoded from cnt=0.
- out_valid=0, busy=0, all live flags clear.

## Timing
- Outputs are combinational decodes of the registered cnt, state and flags; in_ready, in_take and pipe_en also depend combinationally on in_valid.
- Latency: 36 pipe_en cycles from taking sample 0 to out_valid for out_idx=0.
- Back-to-back frames produce contiguous 32-sample output bursts.
- Counter wrap is modulo 32 everywhere, including the offset subtraction.
- If in_valid is high in FLUSH while cnt≠0, it is ignored (in_ready=0) and no sample is taken.
- Reset in any state, mid-frame or mid-flush: the next cycle shows reset values, live flags are cleared, and no out_valid is produced afterwards for the aborted frames.

## Test plan
- **Reset:** assert rst for 2 cycles with in_valid=1 → pipe_en=0, out_valid=0, busy=0, cnt=0.
- **Single frame:** in_valid high for 32 cycles starting at cycle 0, then low.
  - FLUSH from cycle 32.
  - out_valid is high for cycles 36–67; out_idx sequence is 0, 16, 8, 24, 4, …, 31.
  - IDLE and busy=0 at cycle 68.
- **Twiddle decode:** at cnt=20 in RUN, check:
  - bf_sel[1]=0, tw_mul[1]=1, tw_addr16=3.
  - bf_sel[0]=1, tw_mul[0]=0, tw_addr32=0.
- **Back-to-back frames:** 64 consecutive valid samples → out_valid high for exactly 64 contiguous cycles, 36–99, with out_idx restarting at 0 at cycle 68.
- **Gaps:** in_valid low for 3 cycles after sample 10 → pipe_en=0 and all outputs held for those cycles; the first output shifts to cycle 39.
- **Flush interaction:** a new frame presented during FLUSH at cnt≠0 is refused. At the next cnt==0 it is taken and the state goes to RUN. A reset asserted mid-flush gives out_valid=0 for all later cycles.
